// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit, 5-stage CPU: opcodes, field widths and
// the hazard-controller FSM encodings.
package cpu_pkg;

    localparam int REGW = 2;
    localparam int OPW  = 4;

    localparam logic [OPW-1:0] OP_ADD  = 4'b0000;
    localparam logic [OPW-1:0] OP_SUB  = 4'b0001;
    localparam logic [OPW-1:0] OP_AND  = 4'b0010;
    localparam logic [OPW-1:0] OP_OR   = 4'b0011;
    localparam logic [OPW-1:0] OP_XOR  = 4'b0100;
    localparam logic [OPW-1:0] OP_SLL  = 4'b0101;
    localparam logic [OPW-1:0] OP_SLT  = 4'b0110;
    localparam logic [OPW-1:0] OP_ADDI = 4'b0111;
    localparam logic [OPW-1:0] OP_LW   = 4'b1000;
    localparam logic [OPW-1:0] OP_SW   = 4'b1001;
    localparam logic [OPW-1:0] OP_BEQ  = 4'b1010;
    localparam logic [OPW-1:0] OP_BNE  = 4'b1011;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef enum logic {
        DEST_RD = 1'b0,
        DEST_RT = 1'b1
    } dest_sel_t;

endpackage

// File: rtl/hazard_decode.sv
// Register-usage decode of an opcode: which source fields are read, whether
// a register is written, and which field names the destination.
module hazard_decode
    import cpu_pkg::*;
(
    input  logic [OPW-1:0] op,
    output logic           reads_rs,
    output logic           reads_rt,
    output logic           writes,
    output dest_sel_t      dest_sel
);

    always_comb begin
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        writes   = 1'b0;
        dest_sel = DEST_RD;
        if (op <= OP_SLT) begin
            reads_rs = 1'b1;
            reads_rt = 1'b1;
            writes   = 1'b1;
        end else if (op == OP_ADDI || op == OP_LW) begin
            reads_rs = 1'b1;
            writes   = 1'b1;
            dest_sel = DEST_RT;
        end else if (op == OP_SW || op == OP_BEQ || op == OP_BNE) begin
            reads_rs = 1'b1;
            reads_rt = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: RAW scoreboard stalls, branch squash, halt drain.
// Optional HAZ_STATS_EN adds saturating stall_cnt / flush_cnt outputs.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REGW  = cpu_pkg::REGW,
    parameter int OPW   = cpu_pkg::OPW,
    parameter int DEPTH = 3
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            id_valid,
    input  logic [OPW-1:0]  id_op,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic [REGW-1:0] id_rd,
    input  logic            branch_taken,
    input  logic            halt_req,
    output logic            pc_hold,
    output logic            ifid_hold,
    output logic            idex_bubble,
    output logic            ifid_flush,
    output logic            exmem_flush,
    output logic            halt_ack,
    output logic [1:0]      state
`ifdef HAZ_STATS_EN
    ,
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt
`endif
);

    logic            reads_rs;
    logic            reads_rt;
    logic            writes;
    dest_sel_t       dest_sel;
    logic [REGW-1:0] dest;
    logic            hazard;
    logic            issue;
    logic [DEPTH-1:0] rs_hit;
    logic [DEPTH-1:0] rt_hit;
    logic [DEPTH-1:0] sb_valid_reg;
    logic [DEPTH-1:0] sb_valid_next;
    logic [REGW-1:0]  sb_dest_reg  [DEPTH];
    logic [REGW-1:0]  sb_dest_next [DEPTH];
    state_t          state_reg;
    state_t          state_next;

    hazard_decode u_decode (
        .op       (id_op),
        .reads_rs (reads_rs),
        .reads_rt (reads_rt),
        .writes   (writes),
        .dest_sel (dest_sel)
    );

    assign dest   = (dest_sel == DEST_RT) ? id_rt : id_rd;
    assign hazard = id_valid && ((reads_rs && id_rs != '0 && |rs_hit) ||
                                 (reads_rt && id_rt != '0 && |rt_hit));
    assign issue  = id_valid && !branch_taken && !halt_req && !hazard;

    // Entry 0 is EX, entry DEPTH-1 is WB; a taken branch squashes what is in EX.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sb
            assign rs_hit[gi] = sb_valid_reg[gi] && (sb_dest_reg[gi] == id_rs);
            assign rt_hit[gi] = sb_valid_reg[gi] && (sb_dest_reg[gi] == id_rt);

            if (gi == 0) begin : g_ex
                assign sb_valid_next[gi] = issue && writes && (dest != '0);
                assign sb_dest_next[gi]  = issue ? dest : '0;
            end else if (gi == 1) begin : g_mem
                assign sb_valid_next[gi] = sb_valid_reg[gi-1] && !branch_taken;
                assign sb_dest_next[gi]  = sb_dest_reg[gi-1];
            end else begin : g_late
                assign sb_valid_next[gi] = sb_valid_reg[gi-1];
                assign sb_dest_next[gi]  = sb_dest_reg[gi-1];
            end

            always_ff @(negedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sb_valid_reg[gi] <= 1'b0;
                    sb_dest_reg[gi]  <= '0;
                end else begin
                    sb_valid_reg[gi] <= sb_valid_next[gi];
                    sb_dest_reg[gi]  <= sb_dest_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = ST_RUN;
        pc_hold     = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (branch_taken) begin
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_next  = ST_FLUSH;
        end else if (halt_req) begin
            pc_hold     = 1'b1;
            idex_bubble = 1'b1;
            // Halted once nothing remains in flight after this edge.
            state_next  = (sb_valid_next == '0) ? ST_HALT : ST_RUN;
        end else if (hazard) begin
            pc_hold     = 1'b1;
            idex_bubble = 1'b1;
            state_next  = ST_STALL;
        end
    end

    assign ifid_hold = pc_hold;
    assign halt_ack  = (state_reg == ST_HALT) && halt_req && !branch_taken;
    assign state     = state_reg;

`ifdef HAZ_STATS_EN
    logic [15:0] stall_cnt_reg;
    logic [15:0] flush_cnt_reg;

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (hazard && !branch_taken && !halt_req && stall_cnt_reg != 16'hFFFF)
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            if (branch_taken && flush_cnt_reg != 16'hFFFF)
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl; expected output vectors are queued
// as each cycle is driven and popped once the outputs for that cycle settle.
module tb_pipe_hazard_ctrl;

    logic       clock;
    logic       reset_n;
    logic       id_valid;
    logic [3:0] id_op;
    logic [1:0] id_rs, id_rt, id_rd;
    logic       branch_taken, halt_req;
    logic       pc_hold, ifid_hold, idex_bubble, ifid_flush, exmem_flush, halt_ack;
    logic [1:0] state;
`ifdef HAZ_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int checks_total  = 0;
    int checks_passed = 0;
    logic [7:0] exp_q [$];
    logic [7:0] obs;

    pipe_hazard_ctrl dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_op        (id_op),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .branch_taken (branch_taken),
        .halt_req     (halt_req),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .idex_bubble  (idex_bubble),
        .ifid_flush   (ifid_flush),
        .exmem_flush  (exmem_flush),
        .halt_ack     (halt_ack),
        .state        (state)
`ifdef HAZ_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    assign obs = {pc_hold, ifid_hold, idex_bubble, ifid_flush, exmem_flush, halt_ack, state};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // {valid, op, rs, rt, rd, branch_taken, halt_req}
    function automatic logic [12:0] mk(logic v, logic [3:0] op, logic [1:0] rs,
                                       logic [1:0] rt, logic [1:0] rd, logic bt, logic hr);
        return {v, op, rs, rt, rd, bt, hr};
    endfunction

    // Inputs change at posedge; outputs are sampled 2 time units later, well
    // before the negedge on which the DUT updates.
    task automatic apply(input logic [12:0] s);
        @(posedge clock);
        {id_valid, id_op, id_rs, id_rt, id_rd, branch_taken, halt_req} = s;
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(13'd0);
    endtask

    task automatic test_reset();
        logic [7:0] e;
        reset_n = 1'b0;
        {id_valid, id_op, id_rs, id_rt, id_rd, branch_taken, halt_req} = 13'd0;
        #2;
        exp_q.push_back(8'b000000_00);
        e = exp_q.pop_front();
        checks_total++;
        if (obs !== e) $display("FAIL reset_idle: got %b expected %b", obs, e);
        else checks_passed++;
        halt_req = 1'b1;
        #1;
        exp_q.push_back(8'b111000_00);
        e = exp_q.pop_front();
        checks_total++;
        if (obs !== e) $display("FAIL reset_halt_req: got %b expected %b", obs, e);
        else checks_passed++;
        halt_req = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_raw_stall();
        logic [12:0] st [6];
        logic [7:0]  ex [6];
        logic [7:0]  e;
        st = '{mk(1, 4'd8, 2'd0, 2'd1, 2'd0, 0, 0),   // LW $1
               mk(1, 4'd6, 2'd1, 2'd2, 2'd3, 0, 0),   // SLT $3,$1,$2
               mk(1, 4'd6, 2'd1, 2'd2, 2'd3, 0, 0),
               mk(1, 4'd6, 2'd1, 2'd2, 2'd3, 0, 0),
               mk(1, 4'd6, 2'd1, 2'd2, 2'd3, 0, 0),
               mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 0, 0)};
        ex = '{8'b000000_00, 8'b111000_00, 8'b111000_01,
               8'b111000_01, 8'b000000_01, 8'b000000_00};
        for (int i = 0; i < 6; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            e = exp_q.pop_front();
            checks_total++;
            if (obs !== e) $display("FAIL raw_stall[%0d]: got %b expected %b", i, obs, e);
            else checks_passed++;
        end
        idle(3);
    endtask

    task automatic test_zero_reg_stream();
        logic [12:0] st [8];
        logic [7:0]  ex [8];
        logic [7:0]  e;
        st = '{mk(1, 4'd0, 2'd0, 2'd0, 2'd0, 0, 0),
               mk(1, 4'd0, 2'd0, 2'd0, 2'd0, 0, 0),
               mk(1, 4'd0, 2'd0, 2'd0, 2'd0, 0, 0),
               mk(1, 4'd0, 2'd0, 2'd0, 2'd0, 0, 0),
               mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 0, 1),   // empty scoreboard halts at once
               mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 0, 1),
               mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 0, 0),
               mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 0, 0)};
        ex = '{8'b000000_00, 8'b000000_00, 8'b000000_00, 8'b000000_00,
               8'b111000_00, 8'b111001_11, 8'b000000_11, 8'b000000_00};
        for (int i = 0; i < 8; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            e = exp_q.pop_front();
            checks_total++;
            if (obs !== e) $display("FAIL zero_stream[%0d]: got %b expected %b", i, obs, e);
            else checks_passed++;
        end
    endtask

    task automatic test_branch_squash();
        logic [12:0] st [4];
        logic [7:0]  ex [4];
        logic [7:0]  e;
        st = '{mk(1, 4'd7, 2'd0, 2'd2, 2'd0, 0, 0),   // ADDI $2
               mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 1, 0),   // BNE taken
               mk(1, 4'd0, 2'd2, 2'd0, 2'd1, 0, 0),   // ADD $1,$2,$0
               mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 0, 0)};
        ex = '{8'b000000_00, 8'b001110_00, 8'b000000_10, 8'b000000_00};
        for (int i = 0; i < 4; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            e = exp_q.pop_front();
            checks_total++;
            if (obs !== e) $display("FAIL branch_squash[%0d]: got %b expected %b", i, obs, e);
            else checks_passed++;
        end
        idle(3);
    endtask

    task automatic test_branch_vs_hazard();
        logic [12:0] st [4];
        logic [7:0]  ex [4];
        logic [7:0]  e;
        st = '{mk(1, 4'd7, 2'd0, 2'd3, 2'd0, 0, 0),   // ADDI $3
               mk(1, 4'd1, 2'd3, 2'd0, 2'd1, 1, 0),   // SUB reads $3, branch same cycle
               mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 0, 0),
               mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 0, 0)};
        ex = '{8'b000000_00, 8'b001110_00, 8'b000000_10, 8'b000000_00};
        for (int i = 0; i < 4; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            e = exp_q.pop_front();
            checks_total++;
            if (obs !== e) $display("FAIL branch_vs_hazard[%0d]: got %b expected %b", i, obs, e);
            else checks_passed++;
        end
        idle(3);
    endtask

    task automatic test_halt_drain();
        logic [12:0] st [8];
        logic [7:0]  ex [8];
        logic [7:0]  e;
        st = '{mk(1, 4'd7, 2'd0, 2'd1, 2'd0, 0, 0),   // ADDI $1
               mk(1, 4'd7, 2'd0, 2'd2, 2'd0, 0, 0),   // ADDI $2
               mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 0, 1),
               mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 0, 1),
               mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 0, 1),
               mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 0, 1),
               mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 0, 0),
               mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 0, 0)};
        ex = '{8'b000000_00, 8'b000000_00, 8'b111000_00, 8'b111000_00,
               8'b111000_00, 8'b111001_11, 8'b000000_11, 8'b000000_00};
        for (int i = 0; i < 8; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            e = exp_q.pop_front();
            checks_total++;
            if (obs !== e) $display("FAIL halt_drain[%0d]: got %b expected %b", i, obs, e);
            else checks_passed++;
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [12:0] st [3];
        logic [7:0]  ex [3];
        logic [7:0]  e;
        st = '{mk(1, 4'd8, 2'd0, 2'd1, 2'd0, 0, 0),
               mk(1, 4'd6, 2'd1, 2'd2, 2'd3, 0, 0),
               mk(1, 4'd6, 2'd1, 2'd2, 2'd3, 0, 0)};
        ex = '{8'b000000_00, 8'b111000_00, 8'b111000_01};
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            e = exp_q.pop_front();
            checks_total++;
            if (obs !== e) $display("FAIL mid_stall[%0d]: got %b expected %b", i, obs, e);
            else checks_passed++;
        end
        #1 reset_n = 1'b0;
        #1;
        exp_q.push_back(8'b000000_00);
        e = exp_q.pop_front();
        checks_total++;
        if (obs !== e) $display("FAIL async_reset: got %b expected %b", obs, e);
        else checks_passed++;
`ifdef HAZ_STATS_EN
        checks_total++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
            $display("FAIL cnt_reset: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        else checks_passed++;
`endif
        @(posedge clock);
        #1 reset_n = 1'b1;
        apply(mk(1, 4'd6, 2'd1, 2'd2, 2'd3, 0, 0));
        exp_q.push_back(8'b000000_00);
        e = exp_q.pop_front();
        checks_total++;
        if (obs !== e) $display("FAIL after_reset: got %b expected %b", obs, e);
        else checks_passed++;
        idle(3);
    endtask

`ifdef HAZ_STATS_EN
    task automatic test_stats();
        apply(mk(1, 4'd8, 2'd0, 2'd1, 2'd0, 0, 0));
        idle(1);
        for (int i = 0; i < 3; i++) apply(mk(1, 4'd6, 2'd1, 2'd2, 2'd3, 0, 0));
        for (int i = 0; i < 4; i++) apply(mk(1, 4'd0, 2'd3, 2'd0, 2'd0, 0, 0));
        idle(1);
        checks_total++;
        if (stall_cnt !== 16'd5) $display("FAIL stall_cnt: got %0d expected 5", stall_cnt);
        else checks_passed++;
        apply(mk(0, 4'd0, 2'd0, 2'd0, 2'd0, 1, 0));
        idle(1);
        checks_total++;
        if (flush_cnt !== 16'd1) $display("FAIL flush_cnt: got %0d expected 1", flush_cnt);
        else checks_passed++;
        idle(3);
    endtask
`endif

    initial begin
        test_reset();
        test_raw_stall();
        test_zero_reg_stream();
        test_branch_squash();
        test_branch_vs_hazard();
        test_halt_drain();
        test_reset_mid_stall();
`ifdef HAZ_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 16-bit, 5-stage pipelined CPU (4 registers, 4-bit opcodes, branch resolved in MEM).
- Replaces the hand-inserted nops: it keeps a scoreboard of in-flight register writes, stalls IF/ID and injects bubbles into ID/EX on RAW hazards, squashes wrong-path instructions on a taken branch, and drains the pipeline on a halt request.
- Sits beside the ID stage and drives the hold, bubble and flush enables of the pipeline registers.

Parameters:
- REGW, 2, register-specifier width (2^REGW registers; register 0 never hazards).
- OPW, 4, opcode width.
- DEPTH, 3, stages from ID/EX issue to register-file write (EX, MEM, WB).

Ports:
- clock  in  1  pipeline clock; all state updates on negedge, matching the datapath.
- reset_n  in  1  reset; asynchronous, active-low.
- id_valid  in  1  IF/ID holds a real instruction.
- id_op  in  OPW  IFID_IR[15:12].
- id_rs  in  REGW  IFID_IR[11:10].
- id_rt  in  REGW  IFID_IR[9:8].
- id_rd  in  REGW  IFID_IR[7:6].
- branch_taken  in  1  EX/MEM branch resolves taken this cycle.
- halt_req  in  1  level request to stop fetching and drain.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF/ID keeps its value.
- idex_bubble  out  1  ID/EX loads an all-zero nop with all controls cleared.
- ifid_flush  out  1  IF/ID loads a nop.
- exmem_flush  out  1  EX/MEM loads a nop.
- halt_ack  out  1  pipeline empty and halted.
- state  out  2  FSM state, for debug.

Behaviour:
- Decode of the ID instruction:
  - Opcodes 0000–0110 (R-type): read rs and rt, write rd.
  - 0111 (ADDI) and 1000 (LW): read rs, write rt.
  - 1001 (SW), 1010 (BEQ), 1011 (BNE): read rs and rt, no write.
  - Opcodes 1100–1111: no reads, no write.
- Scoreboard: DEPTH-entry shift register of {valid, dest} for the EX, MEM and WB stages.
  - Each negedge it shifts EX→MEM→WB.
  - The new EX entry is {issue_writes & dest!=0, dest} when an instruction issues, else invalid.
- hazard = id_valid & (a read register !=0 matches any valid entry's dest).
  - Consequence: a consumer issues exactly 3 cycles after its producer, equivalent to the previous three nops.
- FSM states, all transitions on negedge:
  - RUN=0: normal operation.
  - STALL=1: entered when hazard; returns to RUN when hazard clears.
  - FLUSH=2: one cycle after branch_taken, then RUN.
  - HALT=3: see drain rule below.
- Outputs are combinational from FSM state, scoreboard and inputs.
- Priority: branch_taken > halt_req > hazard.
- branch_taken:
  - Assert ifid_flush, idex_bubble and exmem_flush; pc_hold=0.
  - The next scoreboard EX entry is invalid.
  - The existing EX entry shifts into MEM marked invalid, because it is squashed.
  - branch_taken during STALL or HALT overrides: the flush is taken and the FSM goes to FLUSH.
- hazard (no branch): pc_hold=ifid_hold=idex_bubble=1; the scoreboard shifts an invalid entry in.
- halt_req (no branch):
  - pc_hold=ifid_hold=idex_bubble=1 every cycle.
  - Once every scoreboard entry is invalid, the FSM enters HALT and halt_ack=1.
  - Dropping halt_req returns the FSM to RUN on the next negedge; halt_ack falls in that same cycle.
- id_valid=0 means no hazard and no issue.
- Reset (asynchronous, any state, including mid-stall or mid-flush): scoreboard cleared, state=RUN, halt_ack=0. All other outputs follow from the cleared state and are therefore 0 unless branch_taken or halt_req is already asserted.

Optional Feature:
- HAZ_STATS_EN defined:
  - Adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments on each hazard-stall cycle; flush_cnt increments on each branch_taken cycle.
  - Both saturate at 16'hFFFF and are cleared by reset_n.
- Not defined: the counters and their ports are absent.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_ADD..OP_BNE;
  - REGW and OPW;
  - FSM state encodings ST_RUN, ST_STALL, ST_FLUSH, ST_HALT.
- Sub-module hazard_decode: purely combinational op → {reads_rs, reads_rt, writes, dest_sel}. Reused later by a forwarding unit.

Test Plan:
1. LW $1 then SLT $3,$1,$2 back-to-back → pc_hold/idex_bubble high exactly 3 cycles, SLT issues on the 4th, state 1,1,1,0.
2. ADD $0,$0,$0 (0x0000) stream → never stalls; scoreboard stays all-invalid.
3. BNE taken while an ADDI writing $2 sits in EX → ifid_flush=idex_bubble=exmem_flush=1 for one cycle. A following read of $2 issues without stalling.
4. branch_taken in the same cycle as a hazard → flush wins; state goes to FLUSH, not STALL.
5. halt_req with 2 writers in flight → halt_ack rises after 3 cycles. Deassert → RUN next negedge.
6. reset_n low mid-stall → outputs 0 immediately, state=RUN. With HAZ_STATS_EN: stall_cnt=0 after reset, and 5 after 5 stall cycles.
